// File: rtl/sb_stream_pkg.sv
// Shared types and widths for the switchboard stream loopback initiator.
package sb_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int PAYLOAD_W = 64;
  localparam int CNT_W     = 16;

  // Pointer width for a power-of-2 FIFO; a depth of 1 still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_expect_fifo.sv
// DEPTH x W sync FIFO of expected replies; head is combinational from the read pointer.
// Push while full and pop while empty are ignored; clear empties it in one cycle.
module sb_expect_fifo
  import sb_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PAYLOAD_W
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(DEPTH):0]     count
);

  localparam int AW = ptr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/sb_stream_initiator.sv
// Counting-payload stream source that checks replies equal payload+ADDEND; TX beat one cycle
// after start, never more than DEPTH replies outstanding; TX holds under !tx_ready, RX always ready while busy.
module sb_stream_initiator
  import sb_stream_pkg::*;
#(
  parameter int          DW      = 256,
  parameter int          N_PKTS  = 16,
  parameter logic [63:0] ADDEND  = 64'd42,
  parameter logic [63:0] SEED    = 64'h0,
  parameter logic [31:0] DEST    = 32'h0,
  parameter int          DEPTH   = 4,
  parameter int          TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  output logic [DW-1:0]    tx_data,
  output logic [31:0]      tx_dest,
  output logic             tx_last,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [DW-1:0]    rx_data,
  input  logic [31:0]      rx_dest,
  input  logic             rx_last,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] rx_count
);

  localparam int CW = ptr_w(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [PAYLOAD_W-1:0] payload, head;
  logic [CNT_W-1:0]     sent, sent_next, rxc_next, err_next;
  logic [TW-1:0]        idle_cnt;
  logic [CW-1:0]        occ, occ_next;
  logic                 fifo_full, fifo_empty, fifo_clear;
  logic                 tx_fire, rx_fire, pop, rx_bad;
  logic                 unused_rx;

  assign tx_dest   = DEST;
  assign tx_last   = 1'b1;
  assign rx_ready  = busy;
  assign unused_rx = |(rx_data >> PAYLOAD_W);

  always_comb begin
    tx_data                  = '0;
    tx_data[PAYLOAD_W-1:0]   = payload;
  end

  always_comb begin
    tx_fire    = tx_valid && tx_ready;
    rx_fire    = rx_valid && rx_ready;
    pop        = rx_fire && !fifo_empty;
    rx_bad     = rx_fire && (fifo_empty || (rx_data[PAYLOAD_W-1:0] != head) ||
                             !rx_last || (rx_dest != DEST));
    fifo_clear = start && ((state == IDLE) || (state == DONE));
    occ_next   = occ + CW'(tx_fire) - CW'(pop);
    sent_next  = sent + CNT_W'(tx_fire);
    rxc_next   = (rx_fire && (rx_count != '1)) ? rx_count + CNT_W'(1) : rx_count;
    err_next   = (rx_bad && (err_count != '1)) ? err_count + CNT_W'(1) : err_count;
  end

  sb_expect_fifo #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_expect (
    .clk    (clk),
    .nreset (nreset),
    .clear  (fifo_clear),
    .push   (tx_fire),
    .pop    (pop),
    .din    (payload + ADDEND),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (occ)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      payload   <= '0;
      sent      <= '0;
      idle_cnt  <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      rx_count  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            payload   <= SEED;
            sent      <= '0;
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            rx_count  <= '0;
          end
        end
        RUN: begin
          rx_count  <= rxc_next;
          err_count <= err_next;
          sent      <= sent_next;
          if (tx_fire) payload <= payload + PAYLOAD_W'(1);
          // tx_valid looks at next-cycle occupancy so a full FIFO is never overrun
          if (sent_next == CNT_W'(N_PKTS)) begin
            state    <= DRAIN;
            tx_valid <= 1'b0;
            idle_cnt <= '0;
          end else begin
            tx_valid <= (occ_next < CW'(DEPTH)) && !fifo_full;
          end
        end
        DRAIN: begin
          rx_count  <= rxc_next;
          err_count <= err_next;
          if (occ_next == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0) && (rxc_next == CNT_W'(N_PKTS));
          end else if (rx_fire) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_stream_initiator.sv
// Loopback bench: behavioural +ADDEND responder with fault injection and a reply scoreboard.
module tb_sb_stream_initiator;

  localparam int          DW    = 256;
  localparam int          N     = 16;
  localparam int          DEPTH = 4;
  localparam int          TMO   = 64;
  localparam logic [63:0] ADD   = 64'd42;
  localparam logic [63:0] SEED  = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [31:0] DEST  = 32'h0000_00A5;

  logic          clk = 1'b0, nreset = 1'b0, start = 1'b0, tx_ready = 1'b0;
  logic          rx_last = 1'b0, rx_valid = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [31:0]   rx_dest = '0;
  logic [DW-1:0] tx_data;
  logic [31:0]   tx_dest;
  logic          tx_last, tx_valid, rx_ready, busy, done, pass, timeout;
  logic [15:0]   err_count, rx_count;

  sb_stream_initiator #(
    .DW(DW), .N_PKTS(N), .ADDEND(ADD), .SEED(SEED), .DEST(DEST), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0]   exp_q[$];   // payloads the DUT must send, in order
  logic [63:0]   m_fifo[$];  // replies the DUT should be expecting
  logic [63:0]   rsp_q[$];
  int            rsp_t[$];
  int            cyc = 0, n_tx, m_rx, m_err, last_rx;
  int            rdy_pct, dly, bad_idx, drop_idx;
  bit            spur_en, spur_done, stall_pend, cur_spur;
  logic [DW-1:0] stall_dat;

  task automatic step(input bit st);
    logic [63:0] v, e;
    @(negedge clk);
    cyc++;
    if (stall_pend) begin
      check("tx_hold_vld", tx_valid, 1'b1);
      check("tx_hold_dat", tx_data, stall_dat);
    end
    start    = st;
    tx_ready = ($urandom_range(99) < rdy_pct);
    cur_spur = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    rx_dest  = DEST;
    rx_last  = 1'b1;
    if (spur_en && !spur_done && busy && m_fifo.size() == 0) begin
      cur_spur = 1'b1;
      rx_valid = 1'b1;
      rx_data  = {192'd0, 64'hDEAD_BEEF};
    end else if (rsp_q.size() > 0 && rsp_t[0] <= cyc) begin
      rx_valid = 1'b1;
      rx_data  = {192'd0, rsp_q[0]};
    end
    #1;
    if (tx_valid) check("outstanding", m_fifo.size() < DEPTH, 1'b1);
    stall_pend = tx_valid && !tx_ready;
    stall_dat  = tx_data;
    if (rx_valid && rx_ready) begin
      m_rx++;
      last_rx = cyc;
      if (cur_spur) begin
        spur_done = 1'b1;
        v = 64'hDEAD_BEEF;
      end else begin
        v = rsp_q.pop_front();
        void'(rsp_t.pop_front());
      end
      if (m_fifo.size() == 0) m_err++;
      else if (m_fifo.pop_front() != v) m_err++;
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_extra", n_tx + 1, N);
      end else begin
        e = exp_q.pop_front();
        check("tx_dat", tx_data, {192'd0, e});
        check("tx_dest", tx_dest, DEST);
        m_fifo.push_back(e + ADD);
        if (n_tx != drop_idx) begin
          rsp_q.push_back(tx_data[63:0] + ((n_tx == bad_idx) ? ADD - 64'd1 : ADD));
          rsp_t.push_back(cyc + dly);
        end
      end
      n_tx++;
    end
  endtask

  task automatic setup(input int rdy, input int d, input int bad, input int drop, input bit spur);
    rdy_pct = rdy; dly = d; bad_idx = bad; drop_idx = drop; spur_en = spur;
    spur_done = 1'b0; stall_pend = 1'b0;
    n_tx = 0; m_rx = 0; m_err = 0; last_rx = 0;
    exp_q.delete(); m_fifo.delete(); rsp_q.delete(); rsp_t.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(SEED + 64'(i));
  endtask

  task automatic run_test(input string tag, input int rdy, input int d, input int bad,
                          input int drop, input bit spur, input int smid);
    bit got;
    int rc;
    setup(rdy, d, bad, drop, spur);
    step(1'b1);
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      step(k == smid);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, got, 1'b1);
    if (got) begin
      check({tag, "_pass"}, pass, (m_err == 0) && (m_rx == N) && (drop < 0));
      check({tag, "_timeout"}, timeout, drop >= 0);
      check({tag, "_err"}, err_count, m_err);
      check({tag, "_rxcnt"}, rx_count, m_rx);
      check({tag, "_ntx"}, n_tx, N);
      check({tag, "_busy"}, busy, 1'b0);
      if (drop >= 0) check({tag, "_tmo_lat"}, cyc - 1 - last_rx, TMO);
      rc = m_rx;
      step(1'b0);
      check({tag, "_hold_done"}, done, 1'b1);
      check({tag, "_hold_rx"}, rx_count, rc);
    end
  endtask

  initial begin
    setup(100, 2, -1, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_cnts", {timeout, err_count, rx_count}, 33'd0);
    nreset = 1'b1;
    repeat (2) step(1'b0);

    run_test("loopback", 100, 2, -1, -1, 1'b0, -1);
    run_test("backpress", 30, 6, -1, -1, 1'b0, -1);
    run_test("corrupt", 100, 2, 5, -1, 1'b0, -1);
    run_test("drop", 100, 2, -1, 9, 1'b0, -1);
    run_test("spurious", 100, 3, -1, -1, 1'b1, 5);

    // abort a run midway with an asynchronous reset
    setup(100, 3, -1, -1, 1'b0);
    step(1'b1);
    repeat (6) step(1'b0);
    check("mid_busy_pre", busy, 1'b1);
    #2 nreset = 1'b0;
    #1;
    check("mid_tx_valid", tx_valid, 1'b0);
    check("mid_tx_data", tx_data, '0);
    check("mid_busy", busy, 1'b0);
    check("mid_rx_ready", rx_ready, 1'b0);
    check("mid_flags", {done, pass, timeout}, 3'b000);
    check("mid_cnts", {err_count, rx_count}, 32'd0);
    rx_valid = 1'b0;
    start    = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    run_test("post_rst", 100, 2, -1, -1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
